// File: rtl/addsub_pkg.sv
// Shared constants for the adder_subtractor datapath stage: op encoding and default width.
package addsub_pkg;
   localparam int   ADDSUB_WIDTH  = 4;
   localparam logic ADDSUB_OP_ADD = 1'b0;
   localparam logic ADDSUB_OP_SUB = 1'b1;
endpackage

// File: rtl/adder_subtractor_if.sv
// Operand/result bundle for adder_subtractor; ovf exists only when ADDSUB_OVERFLOW_EN is defined.
// Handshake: valid-only, no ready. A/B/CTR are taken on any rising edge with in_valid=1;
// out_valid marks the edge on which S/sign/Cout(/ovf) were updated. There is no back-pressure.
interface adder_subtractor_if import addsub_pkg::*; #(
   parameter int WIDTH = ADDSUB_WIDTH
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CTR;
   logic             in_valid;
   logic [WIDTH-1:0] S;
   logic             sign;
   logic             Cout;
   logic             out_valid;
`ifdef ADDSUB_OVERFLOW_EN
   logic             ovf;
`endif

   modport master (
      output A, B, CTR, in_valid,
      input  S, sign, Cout, out_valid
`ifdef ADDSUB_OVERFLOW_EN
      , input ovf
`endif
   );

   modport slave (
      input  A, B, CTR, in_valid,
      output S, sign, Cout, out_valid
`ifdef ADDSUB_OVERFLOW_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/adder_subtractor_full_adder.sv
// One-bit full adder cell; the top chains WIDTH of these into the ripple-carry path.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_subtractor.sv
// Registered unsigned adder/subtractor with sign-magnitude subtract result.
// Optional macro ADDSUB_OVERFLOW_EN adds a registered two's-complement overflow flag (ovf).
module adder_subtractor import addsub_pkg::*; #(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   adder_subtractor_if.slave   bus
);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             sub;
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] r;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] neg_r;
   logic [WIDTH-1:0] s_next;
   logic             sign_next;

   logic [WIDTH-1:0] s_q;
   logic             sign_q;
   logic             cout_q;
   logic             valid_q;

   // Subtract reuses the adder: A + ~B + 1 over the same ripple chain.
   assign sub      = (bus.CTR == ADDSUB_OP_SUB);
   assign b_x      = bus.B ^ {WIDTH{sub}};
   assign carry[0] = sub;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a   (bus.A[i]),
         .b   (b_x[i]),
         .cin (carry[i]),
         .s   (r[i]),
         .cout(carry[i+1])
      );
   end

   // A borrow (carry out 0 on subtract) means A<B: report |A-B| with sign set.
   assign neg_r     = ~r + ONE;
   assign sign_next = sub & ~carry[WIDTH];
   assign s_next    = sign_next ? neg_r : r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= '0;
         sign_q  <= 1'b0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s_q    <= s_next;
            sign_q <= sign_next;
            cout_q <= carry[WIDTH];
         end
      end
   end

   assign bus.S         = s_q;
   assign bus.sign      = sign_q;
   assign bus.Cout      = cout_q;
   assign bus.out_valid = valid_q;

`ifdef ADDSUB_OVERFLOW_EN
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (bus.in_valid) begin
         ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end

   assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor; honours ADDSUB_OVERFLOW_EN when defined.
module tb_adder_subtractor;
   import addsub_pkg::*;

   localparam int W = ADDSUB_WIDTH;
`ifdef ADDSUB_OVERFLOW_EN
   localparam int EW = W + 3;
`else
   localparam int EW = W + 2;
`endif

   logic clk;
   logic rst_n;

   adder_subtractor_if #(.WIDTH(W)) bus ();

   adder_subtractor #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] last_exp;
   int            tests;
   int            fails;

   // Independent reference: plain integer arithmetic, no carry-chain tricks.
   function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ctr);
      logic [W:0]   sum;
      logic [W-1:0] s;
      logic [W-1:0] raw;
      logic         co;
      logic         sg;
      logic         ov;
      if (ctr == ADDSUB_OP_ADD) begin
         sum = {1'b0, a} + {1'b0, b};
         s   = sum[W-1:0];
         co  = sum[W];
         sg  = 1'b0;
         ov  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         raw = a - b;
         if (a >= b) begin
            s  = a - b;
            co = 1'b1;
            sg = 1'b0;
         end else begin
            s  = b - a;
            co = 1'b0;
            sg = 1'b1;
         end
         ov = (a[W-1] != b[W-1]) && (raw[W-1] != a[W-1]);
      end
`ifdef ADDSUB_OVERFLOW_EN
      return {ov, sg, co, s};
`else
      if (ov) begin end
      return {sg, co, s};
`endif
   endfunction

   function automatic logic [EW-1:0] observed();
`ifdef ADDSUB_OVERFLOW_EN
      return {bus.ovf, bus.sign, bus.Cout, bus.S};
`else
      return {bus.sign, bus.Cout, bus.S};
`endif
   endfunction

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor: every out_valid cycle consumes one expected result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", {EW{1'b1}}, {EW{1'b0}});
         end else begin
            last_exp = exp_q.pop_front();
            check("result", observed(), last_exp);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ctr);
      bus.A        = a;
      bus.B        = b;
      bus.CTR      = ctr;
      bus.in_valid = 1'b1;
      exp_q.push_back(model(a, b, ctr));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.A        = W'($urandom_range(0, (1 << W) - 1));
      bus.B        = W'($urandom_range(0, (1 << W) - 1));
      bus.CTR      = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      tests        = 0;
      fails        = 0;
      rst_n        = 1'b1;
      bus.A        = '0;
      bus.B        = '0;
      bus.CTR      = 1'b0;
      bus.in_valid = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      check("reset_outputs", observed(), {EW{1'b0}});
      check("reset_out_valid", {{(EW-1){1'b0}}, bus.out_valid}, {EW{1'b0}});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Test-plan vectors, back to back (CTR changes have no penalty).
      drive(4'b1111, 4'b0111, ADDSUB_OP_ADD);
      drive(4'b0000, 4'b0001, ADDSUB_OP_SUB);
      drive(4'b0101, 4'b0101, ADDSUB_OP_SUB);
      drive(4'b0000, 4'b1111, ADDSUB_OP_SUB);
      drive(4'b1001, 4'b0011, ADDSUB_OP_SUB);
      drive(4'b0111, 4'b0001, ADDSUB_OP_ADD);
      drive(4'b1000, 4'b1000, ADDSUB_OP_SUB);
      drive(4'b1000, 4'b0001, ADDSUB_OP_SUB);

      // Randomised ops with alternating bubbles.
      for (int i = 0; i < 24; i++) begin
         drive(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
               1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle();
      end
      drive(4'b1100, 4'b0110, ADDSUB_OP_ADD);

      // Hold: bubble cycle keeps the last result, out_valid low.
      idle();
      @(negedge clk);
      check("hold_outputs", observed(), last_exp);
      check("hold_out_valid", {{(EW-1){1'b0}}, bus.out_valid}, {EW{1'b0}});

      // Asynchronous reset pulse between edges.
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", observed(), {EW{1'b0}});
      check("async_reset_out_valid", {{(EW-1){1'b0}}, bus.out_valid}, {EW{1'b0}});
      #1 rst_n = 1'b1;
      idle();
      @(negedge clk);
      check("post_reset_idle", observed(), {EW{1'b0}});

      // Capture resumes after reset.
      #1;
      drive(4'b0011, 4'b1010, ADDSUB_OP_SUB);
      drive(4'b1110, 4'b0001, ADDSUB_OP_ADD);
      idle();
      idle();

      check("queue_drained", EW'(exp_q.size()), {EW{1'b0}});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
